// File: rtl/pkt_fifo_ctrl_v2_if.sv
// Word-stream link used on both sides of the packet FIFO.
// The master drives data/ctrl/wr; the slave answers with rdy.
interface pkt_fifo_ctrl_v2_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] data;
    logic [CTRL_WIDTH-1:0] ctrl;
    logic                  wr;
    logic                  rdy;

    modport master (output data, output ctrl, output wr, input rdy);
    modport slave  (input data, input ctrl, input wr, output rdy);
endinterface

// File: rtl/pkt_fifo_ctrl_v2.sv
// Convertible packet FIFO: holds one whole packet, lets the processor
// read/patch it, then drains it downstream (or drains directly on bypass).
// Oversize packets are discarded and counted.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a module-header word (ctrl!=0); ctrl==0 ignored
// HEADER  | storing module headers and NUM_HDR_WORDS ctrl==0 headers
// PAYLOAD | storing payload until the end-of-packet word (ctrl!=0)
// DISCARD | packet overflowed the buffer; dropping up to end-of-packet
// PROC    | packet owned by the processor (pkt_ready=1)
// DRAIN   | streaming mem[0 .. pkt_len-1] out, honouring out_rdy
module pkt_fifo_ctrl_v2 #(
    parameter int DATA_WIDTH     = 64,
    parameter int CTRL_WIDTH     = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int NUM_HDR_WORDS  = 3,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    pkt_fifo_ctrl_v2_if.slave         in_bus,
    pkt_fifo_ctrl_v2_if.master        out_bus,
    input  logic                      bypass,
    input  logic [ADDR_WIDTH-1:0]     cpu_addr,
    input  logic [DATA_WIDTH-1:0]     cpu_din,
    input  logic                      cpu_wen,
    input  logic                      cpu_done,
    output logic [DATA_WIDTH-1:0]     cpu_dout,
    output logic [CTRL_WIDTH-1:0]     cpu_ctrl_dout,
    output logic                      pkt_ready,
    output logic [ADDR_WIDTH:0]       pkt_len,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);
    localparam int DEPTH     = 1 << ADDR_WIDTH;
    localparam int HDR_CNT_W = (NUM_HDR_WORDS > 1) ? $clog2(NUM_HDR_WORDS) : 1;

    localparam logic [ADDR_WIDTH:0]  PTR_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [HDR_CNT_W-1:0] HDR_LAST = HDR_CNT_W'(NUM_HDR_WORDS - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HEADER  = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
    localparam logic [2:0] ST_DISCARD = 3'd3;
    localparam logic [2:0] ST_PROC    = 3'd4;
    localparam logic [2:0] ST_DRAIN   = 3'd5;

    logic [2:0]            state;
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [HDR_CNT_W-1:0]  hdr_cnt;

    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic [CTRL_WIDTH-1:0] mem_ctrl [DEPTH];

    logic                  in_rdy_int;
    logic                  in_acc;
    logic                  in_eop;
    logic                  overflow;
    logic                  storing;
    logic                  store_ing;
    logic                  drop_evt;
    logic                  cpu_wr;
    logic                  issue;
    logic [ADDR_WIDTH-1:0] wr_idx;

    assign in_rdy_int = (state == ST_IDLE) || (state == ST_HEADER) ||
                        (state == ST_PAYLOAD) || (state == ST_DISCARD);
    assign in_bus.rdy = in_rdy_int;
    assign pkt_ready  = (state == ST_PROC);

    assign in_acc    = in_bus.wr && in_rdy_int;
    assign in_eop    = |in_bus.ctrl;
    assign overflow  = (wr_ptr == PTR_FULL);
    assign storing   = (state == ST_HEADER) || (state == ST_PAYLOAD);
    assign store_ing = in_acc && (((state == ST_IDLE) && in_eop) || (storing && !overflow));
    assign drop_evt  = in_acc && storing && overflow;
    assign cpu_wr    = (state == ST_PROC) && cpu_wen;
    assign issue     = (state == ST_DRAIN) && out_bus.rdy && (rd_ptr < pkt_len);
    // wr_ptr is left stale after a packet; the first word always lands at 0
    assign wr_idx    = (state == ST_IDLE) ? '0 : wr_ptr[ADDR_WIDTH-1:0];

    // Packet sequencing: pointers, header counting, ownership hand-off
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            hdr_cnt <= '0;
            pkt_len <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_acc && in_eop) begin
                        wr_ptr  <= (ADDR_WIDTH+1)'(1);
                        hdr_cnt <= '0;
                        state   <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (in_acc) begin
                        if (overflow) begin
                            state <= ST_DISCARD;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                            if (!in_eop) begin
                                if (hdr_cnt == HDR_LAST)
                                    state <= ST_PAYLOAD;
                                else
                                    hdr_cnt <= hdr_cnt + 1'b1;
                            end
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (in_acc) begin
                        if (overflow) begin
                            // an overflowing end-of-packet word already closes the packet
                            state <= in_eop ? ST_IDLE : ST_DISCARD;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                            if (in_eop) begin
                                pkt_len <= wr_ptr + 1'b1;
                                rd_ptr  <= '0;
                                state   <= bypass ? ST_DRAIN : ST_PROC;
                            end
                        end
                    end
                end
                ST_DISCARD: begin
                    if (in_acc && in_eop)
                        state <= ST_IDLE;
                end
                ST_PROC: begin
                    if (cpu_done) begin
                        rd_ptr <= '0;
                        state  <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (issue) begin
                        rd_ptr <= rd_ptr + 1'b1;
                        if ((rd_ptr + 1'b1) == pkt_len)
                            state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Saturating count of dropped oversize packets
    always_ff @(posedge clk) begin
        if (reset)
            drop_cnt <= '0;
        else if (drop_evt && (drop_cnt != '1))
            drop_cnt <= drop_cnt + 1'b1;
    end

    // Packet buffer: ingress writes data+ctrl, processor patches data only
    always_ff @(posedge clk) begin
        if (store_ing) begin
            mem_data[wr_idx] <= in_bus.data;
            mem_ctrl[wr_idx] <= in_bus.ctrl;
        end else if (cpu_wr) begin
            mem_data[cpu_addr] <= cpu_din;
        end
    end

    // Registered processor read port, live in every state
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_dout      <= '0;
            cpu_ctrl_dout <= '0;
        end else begin
            cpu_dout      <= mem_data[cpu_addr];
            cpu_ctrl_dout <= mem_ctrl[cpu_addr];
        end
    end

    // Egress register: one word per granted cycle, holds value when idle
    always_ff @(posedge clk) begin
        if (reset) begin
            out_bus.wr   <= 1'b0;
            out_bus.data <= '0;
            out_bus.ctrl <= '0;
        end else begin
            out_bus.wr <= issue;
            if (issue) begin
                out_bus.data <= mem_data[rd_ptr[ADDR_WIDTH-1:0]];
                out_bus.ctrl <= mem_ctrl[rd_ptr[ADDR_WIDTH-1:0]];
            end
        end
    end
endmodule

// File: tb/tb_pkt_fifo_ctrl_v2.sv
// Bench for pkt_fifo_ctrl_v2 with a 16-word buffer. Packets are built as
// queues; the expected egress is the packet itself (with any processor
// patch applied) or nothing when it is longer than the buffer.
module tb_pkt_fifo_ctrl_v2;
    localparam int DW  = 64;
    localparam int CW  = 8;
    localparam int AW  = 4;
    localparam int NH  = 3;
    localparam int DCW = 16;
    localparam int DEPTH = 1 << AW;

    typedef logic [CW+DW-1:0] word_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            bypass = 1'b0;
    logic [AW-1:0]   cpu_addr = '0;
    logic [DW-1:0]   cpu_din = '0;
    logic            cpu_wen = 1'b0;
    logic            cpu_done = 1'b0;
    logic [DW-1:0]   cpu_dout;
    logic [CW-1:0]   cpu_ctrl_dout;
    logic            pkt_ready;
    logic [AW:0]     pkt_len;
    logic [DCW-1:0]  drop_cnt;

    pkt_fifo_ctrl_v2_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) in_if ();
    pkt_fifo_ctrl_v2_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) out_if ();

    pkt_fifo_ctrl_v2 #(
        .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .ADDR_WIDTH(AW),
        .NUM_HDR_WORDS(NH), .DROP_CNT_WIDTH(DCW)
    ) dut (
        .clk(clk), .reset(reset),
        .in_bus(in_if.slave), .out_bus(out_if.master),
        .bypass(bypass), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_wen(cpu_wen), .cpu_done(cpu_done), .cpu_dout(cpu_dout),
        .cpu_ctrl_dout(cpu_ctrl_dout), .pkt_ready(pkt_ready),
        .pkt_len(pkt_len), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int     n_pass = 0;
    int     n_fail = 0;
    int     n_total = 0;
    int     exp_drop = 0;
    int     exp_len = 0;
    bit     rand_rdy = 0;
    int     ready_cnt = 0;
    word_t  pkt_q[$];
    word_t  exp_q[$];
    word_t  got_q[$];

    // Egress monitor: the only writer of got_q and ready_cnt
    always @(negedge clk) begin
        if (out_if.wr === 1'b1) got_q.push_back({out_if.ctrl, out_if.data});
        if (pkt_ready === 1'b1) ready_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) out_if.rdy = ($urandom_range(0, 3) != 0);
    endtask

    task automatic build_pkt(input int n_pay);
        logic [CW-1:0] eop_ctrl;
        pkt_q.delete();
        pkt_q.push_back({8'hFF, $urandom, $urandom});
        for (int i = 0; i < NH + n_pay; i++) pkt_q.push_back({8'h00, $urandom, $urandom});
        eop_ctrl = 8'h01 << $urandom_range(0, 7);
        pkt_q.push_back({eop_ctrl, $urandom, $urandom});
    endtask

    task automatic send_pkt();
        int t;
        foreach (pkt_q[i]) begin
            in_if.wr   = 1'b1;
            in_if.ctrl = pkt_q[i][CW+DW-1:DW];
            in_if.data = pkt_q[i][DW-1:0];
            t = 0;
            while (in_if.rdy !== 1'b1 && t < 100) begin step(); t++; end
            if (in_if.rdy !== 1'b1) chk("in_rdy_wait", in_if.rdy, 1);
            step();
        end
        in_if.wr = 1'b0;
    endtask

    // One packet end to end. edit: 0 none, 1 write+readback+done, 2 write with done
    task automatic run_pkt(input int n_pay, input bit byp, input int edit,
                           input int eaddr, input logic [DW-1:0] edata, input bit stall);
        int base, r0, len, t;
        bit dropped;
        word_t w;
        build_pkt(n_pay);
        len = pkt_q.size();
        dropped = (len > DEPTH);
        bypass = byp;
        base = got_q.size();
        r0 = ready_cnt;
        exp_q = pkt_q;
        send_pkt();
        if (dropped) begin
            exp_drop++;
            for (int i = 0; i < 6; i++) step();
            chk("drop_cnt", drop_cnt, exp_drop);
            chk("drop_no_egress", got_q.size(), base);
            chk("drop_pkt_len_held", pkt_len, exp_len);
            chk("drop_in_rdy", in_if.rdy, 1);
        end else begin
            exp_len = len;
            if (!byp) begin
                t = 0;
                while (pkt_ready !== 1'b1 && t < 50) begin step(); t++; end
                chk("pkt_ready", pkt_ready, 1);
                chk("proc_in_blocked", in_if.rdy, 0);
                chk("proc_pkt_len", pkt_len, exp_len);
                if (edit != 0) begin
                    w = exp_q[eaddr];
                    w[DW-1:0] = edata;
                    exp_q[eaddr] = w;
                    cpu_addr = AW'(eaddr);
                    cpu_din = edata;
                    cpu_wen = 1'b1;
                    if (edit == 2) cpu_done = 1'b1;
                    step();
                    cpu_wen = 1'b0;
                    if (edit == 1) begin
                        step();
                        chk("cpu_dout_readback", cpu_dout, edata);
                        chk("cpu_ctrl_readback", cpu_ctrl_dout, w[CW+DW-1:DW]);
                    end
                end
                if (cpu_done !== 1'b1) begin
                    cpu_done = 1'b1;
                    step();
                end
                cpu_done = 1'b0;
            end else if (stall) begin
                for (int i = 0; i < 3; i++) step();
                out_if.rdy = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    step();
                    chk("stall_out_wr", out_if.wr, 0);
                end
                out_if.rdy = 1'b1;
            end
            t = 0;
            while (got_q.size() < base + len && t < 300) begin step(); t++; end
            for (int i = 0; i < 3; i++) step();
            chk("egress_count", got_q.size() - base, len);
            for (int i = 0; i < len; i++) begin
                w = (base + i < got_q.size()) ? got_q[base + i] : 'x;
                chk($sformatf("egress_word%0d", i), w, exp_q[i]);
            end
            chk("pkt_len", pkt_len, exp_len);
            chk("drop_cnt_keep", drop_cnt, exp_drop);
            chk("idle_in_rdy", in_if.rdy, 1);
            if (byp) chk("bypass_no_ready", ready_cnt - r0, 0);
        end
    endtask

    initial begin
        int t;
        int n_pay, ed, ea;
        in_if.wr = 1'b0;
        in_if.data = '0;
        in_if.ctrl = '0;
        out_if.rdy = 1'b1;

        // reset state
        step(); step();
        chk("rst_in_rdy", in_if.rdy, 1);
        chk("rst_out_wr", out_if.wr, 0);
        chk("rst_out_data", out_if.data, 0);
        chk("rst_out_ctrl", out_if.ctrl, 0);
        chk("rst_cpu_dout", cpu_dout, 0);
        chk("rst_cpu_ctrl", cpu_ctrl_dout, 0);
        chk("rst_pkt_ready", pkt_ready, 0);
        chk("rst_pkt_len", pkt_len, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        reset = 1'b0;
        step();

        // bypass pass-through, 7 words
        run_pkt(2, 1, 0, 0, '0, 0);
        // processor edit at word 5
        run_pkt(2, 0, 1, 5, 64'hDEADBEEF_00000000, 0);
        // backpressure mid-drain
        run_pkt(5, 1, 0, 0, '0, 1);
        // overflow: 18 words dropped, then 5 words intact
        run_pkt(13, 1, 0, 0, '0, 0);
        run_pkt(0, 1, 0, 0, '0, 0);

        // stray ctrl==0 words in IDLE are ignored
        in_if.wr = 1'b1;
        in_if.ctrl = '0;
        for (int i = 0; i < 3; i++) begin in_if.data = {$urandom, $urandom}; step(); end
        in_if.wr = 1'b0;
        // exactly DEPTH words, patched together with release
        run_pkt(11, 0, 2, 15, {$urandom, $urandom}, 0);

        // cpu_done outside PROC does nothing
        cpu_done = 1'b1;
        step();
        cpu_done = 1'b0;
        step();
        chk("idle_done_ignored", in_if.rdy, 1);
        // read port still live in IDLE
        cpu_addr = '0;
        step();
        chk("idle_read_data", cpu_dout, pkt_q[0][DW-1:0]);
        chk("idle_read_ctrl", cpu_ctrl_dout, 8'hFF);

        // randomized packets
        rand_rdy = 1;
        for (int k = 0; k < 10; k++) begin
            n_pay = $urandom_range(0, 14);
            ed = $urandom_range(0, 2);
            ea = $urandom_range(0, n_pay + NH + 1);
            run_pkt(n_pay, 1'($urandom_range(0, 1)), ed, ea, {$urandom, $urandom}, 0);
        end
        rand_rdy = 0;
        out_if.rdy = 1'b1;
        step();

        // reset while the processor owns a packet
        build_pkt(3);
        bypass = 1'b0;
        t = got_q.size();
        send_pkt();
        chk("pre_rst_ready", pkt_ready, 1);
        cpu_addr = AW'(2);
        step();
        reset = 1'b1;
        step();
        chk("mid_rst_pkt_ready", pkt_ready, 0);
        chk("mid_rst_in_rdy", in_if.rdy, 1);
        chk("mid_rst_out_wr", out_if.wr, 0);
        chk("mid_rst_out_data", out_if.data, 0);
        chk("mid_rst_out_ctrl", out_if.ctrl, 0);
        chk("mid_rst_cpu_dout", cpu_dout, 0);
        chk("mid_rst_cpu_ctrl", cpu_ctrl_dout, 0);
        chk("mid_rst_pkt_len", pkt_len, 0);
        chk("mid_rst_drop_cnt", drop_cnt, 0);
        reset = 1'b0;
        exp_drop = 0;
        exp_len = 0;
        step(); step();
        chk("mid_rst_no_egress", got_q.size(), t);
        run_pkt(4, 1, 0, 0, '0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
